// File: rtl/psum_bram_sim_model.sv
// Simple-dual-port partial-sum RAM model: byte-enabled write port, registered read port (1 or 2 cycles).
// Read-first on same-address collision; out-of-range accesses are dropped/zeroed and latch a sticky error.
module psum_bram_sim_model #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_BYTE     = DATA_WIDTH / 8,
   parameter int DEPTH_LOG2   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] idat,
   input  logic [NUM_BYTE-1:0]   wren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] odat,
   output logic                  o_err
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rd1;
   logic                  w_oor;
   logic                  r_oor;
   logic                  w_known;
   logic                  r_known;
   logic                  w_any;

   // Any set bit above the array index means the access is outside the array; no wrap.
   assign w_oor   = (waddr >> DEPTH_LOG2) != '0;
   assign r_oor   = (raddr >> DEPTH_LOG2) != '0;
   assign w_known = !$isunknown({waddr, wren});
   assign r_known = !$isunknown(raddr);
   assign w_any   = |wren;

   // Array has no reset so it maps onto block RAM; reset only gates the write.
   always_ff @(posedge clk) begin
      if (rst && w_known && !w_oor) begin
         for (int i = 0; i < NUM_BYTE; i++) begin
            if (wren[i]) begin
               mem[waddr[DEPTH_LOG2-1:0]][8*i +: 8] <= idat[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd1 <= '0;
      end else if (r_known && !r_oor) begin
         rd1 <= mem[raddr[DEPTH_LOG2-1:0]];
      end else begin
         rd1 <= '0;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] rd2;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rd2 <= '0;
            end else begin
               rd2 <= rd1;
            end
         end
         assign odat = rd2;
      end else begin : g_lat1
         assign odat = rd1;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_err <= 1'b0;
      end else if ((w_known && w_oor && w_any) || (r_known && r_oor)) begin
         o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_bram_sim_model.sv
// Directed bench: one RAM per read latency driven from shared stimulus, checked with immediate assertions.
module tb_psum_bram_sim_model;

   localparam int N = 50176;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] waddr = '0;
   logic [31:0] idat = '0;
   logic [3:0]  wren = '0;
   logic [31:0] raddr = '0;
   logic [31:0] odat1;
   logic [31:0] odat2;
   logic        err1;
   logic        err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psum_bram_sim_model #(.READ_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .waddr(waddr), .idat(idat), .wren(wren),
      .raddr(raddr), .odat(odat1), .o_err(err1)
   );

   psum_bram_sim_model #(.READ_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .waddr(waddr), .idat(idat), .wren(wren),
      .raddr(raddr), .odat(odat2), .o_err(err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      waddr = a;
      idat  = d;
      wren  = be;
      tick();
      wren  = 4'h0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      check("reset_odat_l1", odat1, 32'h0);
      check("reset_odat_l2", odat2, 32'h0);
      check("reset_err_l1", {31'h0, err1}, 32'h0);
      check("reset_err_l2", {31'h0, err2}, 32'h0);

      // Pre-reset write and an out-of-range read so reset has an error to clear.
      wr(32'd5, 32'h0000_5A5A, 4'hF);
      raddr = 32'd65536;
      tick();
      check("oor_read_err", {31'h0, err1}, 32'h1);
      rst = 1'b0;
      #1;
      check("async_reset_odat", odat1, 32'h0);
      check("async_reset_err", {31'h0, err1}, 32'h0);
      waddr = 32'd5;
      idat  = 32'hFFFF_FFFF;
      wren  = 4'hF;
      raddr = 32'd5;
      tick();
      wren = 4'h0;
      rst  = 1'b1;
      tick();
      check("mem_survives_reset_l1", odat1, 32'h0000_5A5A);
      tick();
      check("mem_survives_reset_l2", odat2, 32'h0000_5A5A);

      wr(32'd10, 32'hDEAD_BEEF, 4'hF);
      raddr = 32'd10;
      tick();
      check("full_write_l1", odat1, 32'hDEAD_BEEF);
      tick();
      check("full_write_l2", odat2, 32'hDEAD_BEEF);

      wr(32'd10, 32'h0000_0000, 4'h0);
      tick();
      check("wren_zero_noop", odat1, 32'hDEAD_BEEF);

      wr(32'd3, 32'h1122_3344, 4'hF);
      wr(32'd3, 32'hAABB_CCDD, 4'b0101);
      raddr = 32'd3;
      tick();
      check("byte_enable", odat1, 32'h11BB_33DD);

      wr(32'd7, 32'h0000_0001, 4'hF);
      raddr = 32'd7;
      wr(32'd7, 32'h0000_0002, 4'hF);
      check("collision_read_first", odat1, 32'h0000_0001);
      tick();
      check("collision_next_read", odat1, 32'h0000_0002);
      check("collision_l2_delayed", odat2, 32'h0000_0001);

      wr(32'd0, 32'h1234_5678, 4'hF);
      wr(32'd65535, 32'hCAFE_F00D, 4'hF);
      raddr = 32'd65535;
      tick();
      check("top_addr_read", odat1, 32'hCAFE_F00D);
      check("top_addr_no_err", {31'h0, err1}, 32'h0);
      wr(32'd65536, 32'hFFFF_FFFF, 4'hF);
      check("oor_write_err", {31'h0, err1}, 32'h1);
      raddr = 32'd0;
      tick();
      check("oor_write_no_alias", odat1, 32'h1234_5678);
      raddr = 32'd65536;
      tick();
      check("oor_read_zero", odat1, 32'h0);
      raddr = 32'h8000_0005;
      tick();
      check("oor_high_bit_zero", odat1, 32'h0);
      raddr = 32'd5;
      tick();
      check("err_sticky", {31'h0, err1}, 32'h1);

      // Streaming: write address i while reading address i-1 (written on the previous edge).
      for (int i = 0; i <= N + 1; i++) begin
         waddr = i;
         idat  = i;
         wren  = (i < N) ? 4'hF : 4'h0;
         raddr = (i >= 1 && i <= N) ? i - 1 : ((i > N) ? N - 1 : 0);
         tick();
         if (i >= 1 && i <= N) check("stream_l1", odat1, i - 1);
         if (i >= 2) check("stream_l2", odat2, i - 2);
      end
      wren = 4'h0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
